junction_controller: RTL and testbench
======================================

# junction_controller

Two-road junction sequencer that drives a main-road and a side-road traffic head with per-phase dwell times. Main road rests on green and yields to the side road only on a detected vehicle request after a minimum green time. All-red clearance separates every change of right-of-way. Lamp codes are the team's 3-bit traffic-head encoding, so the block drives the lamp drivers directly.

## Interface
- `TW`, 8: dwell timer width in bits; every `T_*` must lie in 1..2^TW.
- `T_MIN_GREEN`, 16: minimum main green, in cycles.
- `T_SIDE_GREEN`, 12: fixed side green, in cycles.
- `T_AMBER`, 4: amber dwell, both roads.
- `T_RED_AMBER`, 2: red-amber dwell, both roads.
- `T_ALL_RED`, 2: all-red clearance dwell.
- `T_WALK`, 10: pedestrian walk dwell; used only with `PED_CROSSING_EN`.
- `clk` in 1: clock, all logic on rising edge.
- `rst` in 1: reset, synchronous, active-high.
- `side_req` in 1: side-road vehicle sensor, level or pulse.
- `ped_req` in 1: pedestrian button; present only with `PED_CROSSING_EN`.
- `main_light` out 3: main head {red, amber, green}.
- `side_light` out 3: side head, same encoding.
- `walk` out 1: walk lamp; present only with `PED_CROSSING_EN`.

## Operation
- Lamp codes: RED 100, RED_AMBER 110, GREEN 001, AMBER 010.
- States, with {main, side} lamps:
  - MAIN_GREEN {001,100}
  - MAIN_AMBER {010,100}
  - ALL_RED_1 {100,100}
  - SIDE_RED_AMBER {100,110}
  - SIDE_GREEN {100,001}
  - SIDE_AMBER {100,010}
  - ALL_RED_2 {100,100}
  - MAIN_RED_AMBER {110,100}
  - WALK {100,100}, with `walk`=1; this state exists only with the macro.
- Dwell: on entry to a state the timer loads T−1. It decrements each cycle and saturates at 0. "Expired" means the timer equals 0, so each timed state lasts exactly T cycles.
- Transitions:
  - MAIN_GREEN → MAIN_AMBER when expired and a request is pending. Otherwise MAIN_GREEN holds indefinitely.
  - MAIN_AMBER → ALL_RED_1.
  - ALL_RED_1 → SIDE_RED_AMBER if side is pending. Otherwise → WALK.
  - SIDE_RED_AMBER → SIDE_GREEN → SIDE_AMBER → ALL_RED_2.
  - ALL_RED_2 → WALK if ped is pending. Otherwise → MAIN_RED_AMBER.
  - WALK → MAIN_RED_AMBER.
  - MAIN_RED_AMBER → MAIN_GREEN.
  - All of these except MAIN_GREEN advance only on expiry.
- Pending flags:
  - `side_pend` sets on any cycle `side_req`=1 and clears on entry to SIDE_GREEN. A request arriving while side is already green is re-latched for the next cycle.
  - `ped_pend` behaves the same way with `ped_req`, clearing on entry to WALK.
  - "Pending" in the transition rules means the flag OR the live request input.
- Side has priority over pedestrian at ALL_RED_1. A pedestrian request raised during the side phase is served at ALL_RED_2.
- Illegal state encoding → ALL_RED_2 next cycle, with all-red lamps decoded meanwhile.
- Lamps are a Moore decode of the state register; there is no combinational path from any input to any output.

## Timing
- Reset: state ALL_RED_2, timer=T_ALL_RED−1, pend flags 0, `main_light`=100, `side_light`=100, `walk`=0. Requests are ignored on cycles with `rst`=1.
- Reset mid-sequence behaves identically from any state and abandons the current phase.
- Let E0 be the last edge with `rst`=1. Then MAIN_RED_AMBER from E0+2 and MAIN_GREEN from E0+4.
- Request latency: `side_req` high at edge k with main green already expired gives `main_light`=010 after edge k.
- Main-green-to-main-green side cycle totals 4+2+2+12+4+2+2 = 28 cycles, with default parameters.
- Simultaneous `side_req` and `ped_req`: both latch, side is served first, walk follows at ALL_RED_2.

## Configuration
- `PED_CROSSING_EN` defined: `ped_req` and `walk` ports exist, along with the WALK state, `ped_pend` and `T_WALK`.
- Undefined: those ports and the state are removed. ALL_RED_1 always → SIDE_RED_AMBER and ALL_RED_2 always → MAIN_RED_AMBER.

## Structure
- Package `junction_pkg`: state enum, lamp-code constants, a state→{main, side, walk} decode function.
- Sub-module `dwell_timer`:
  - Parameter TW.
  - Inputs: `load`, `load_val`.
  - Output: `expired`.
  - Behaviour: saturating down-counter with synchronous reset.

## Test plan
- Reset then idle 100 cycles → lamps {100,100} for 2 cycles, {110,100} for 2, then {001,100} held with no further change.
- `side_req` pulse at cycle 5 after MAIN_GREEN entry:
  - MAIN_GREEN holds until 16 cycles are complete, then 010 for 4 cycles, {100,100} for 2, side 110 for 2, side 001 for exactly 12.
  - The sequence returns to main 001 28 cycles after amber starts.
- `side_req` held high continuously → main green lasts exactly 16 cycles each round.
- Macro on, `ped_req` alone → after min green: amber 4, all-red 2, `walk`=1 for 10 cycles, then main 110.
- Macro on, both requests on the same cycle → side phase first, then `walk`=1, then main 110.
- `rst` asserted during SIDE_GREEN → next cycle lamps {100,100}, pend flags clear, and the sequence restarts as in the first scenario.

Source files
------------

// File: rtl/junction_pkg.sv
// junction_pkg: shared types for the two-road junction sequencer.
// State encoding, 3-bit lamp codes {red, amber, green} and the
// state-to-lamp decode used by junction_controller.
package junction_pkg;

   // Sequencer states; WALK is only reachable when PED_CROSSING_EN is defined.
   typedef enum logic [3:0] {
      MAIN_GREEN     = 4'd0,
      MAIN_AMBER     = 4'd1,
      ALL_RED_1      = 4'd2,
      SIDE_RED_AMBER = 4'd3,
      SIDE_GREEN     = 4'd4,
      SIDE_AMBER     = 4'd5,
      ALL_RED_2      = 4'd6,
      MAIN_RED_AMBER = 4'd7,
      WALK           = 4'd8
   } state_t;

   localparam logic [2:0] LAMP_RED       = 3'b100;
   localparam logic [2:0] LAMP_RED_AMBER = 3'b110;
   localparam logic [2:0] LAMP_GREEN     = 3'b001;
   localparam logic [2:0] LAMP_AMBER     = 3'b010;

   typedef struct packed {
      logic [2:0] main_l;
      logic [2:0] side_l;
      logic       walk_l;
   } lamps_t;

   // Moore decode; any encoding outside the enum shows all-red, walk off.
   function automatic lamps_t decode_lamps(input state_t st);
      lamps_t l;
      l.main_l = LAMP_RED;
      l.side_l = LAMP_RED;
      l.walk_l = 1'b0;
      case (st)
         MAIN_GREEN:     l.main_l = LAMP_GREEN;
         MAIN_AMBER:     l.main_l = LAMP_AMBER;
         ALL_RED_1:      l.main_l = LAMP_RED;
         SIDE_RED_AMBER: l.side_l = LAMP_RED_AMBER;
         SIDE_GREEN:     l.side_l = LAMP_GREEN;
         SIDE_AMBER:     l.side_l = LAMP_AMBER;
         ALL_RED_2:      l.main_l = LAMP_RED;
         MAIN_RED_AMBER: l.main_l = LAMP_RED_AMBER;
         WALK:           l.walk_l = 1'b1;
         default: begin
            l.main_l = LAMP_RED;
            l.side_l = LAMP_RED;
            l.walk_l = 1'b0;
         end
      endcase
      return l;
   endfunction

endpackage

// File: rtl/dwell_timer.sv
// dwell_timer: saturating down-counter for per-phase dwell times.
// Loads load_val on load, otherwise counts down and sticks at zero;
// expired is high while the count is zero.
module dwell_timer #(
   parameter int           TW      = 8,
   parameter logic [TW-1:0] RST_VAL = {TW{1'b0}}
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic [TW-1:0] load_val,
   output logic          expired
);

   logic [TW-1:0] cnt_r;

   // Count register: reload on phase entry, else decrement to zero and hold.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r <= RST_VAL;
      end else if (load) begin
         cnt_r <= load_val;
      end else if (cnt_r != {TW{1'b0}}) begin
         cnt_r <= cnt_r - {{(TW-1){1'b0}}, 1'b1};
      end else begin
         cnt_r <= cnt_r;
      end
   end

   assign expired = (cnt_r == {TW{1'b0}});

endmodule

// File: rtl/junction_controller.sv
// junction_controller: main/side road traffic-head sequencer.
// Main road rests on green and yields to a pending side request after the
// minimum green; every right-of-way change passes through all-red.
// Optional pedestrian phase: define PED_CROSSING_EN to add ped_req, walk,
// the WALK state and the T_WALK dwell.
module junction_controller
   import junction_pkg::*;
#(
   parameter int TW           = 8,
   parameter int T_MIN_GREEN  = 16,
   parameter int T_SIDE_GREEN = 12,
   parameter int T_AMBER      = 4,
   parameter int T_RED_AMBER  = 2,
   parameter int T_ALL_RED    = 2
`ifdef PED_CROSSING_EN
   ,
   parameter int T_WALK       = 10
`endif
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       side_req,
`ifdef PED_CROSSING_EN
   input  logic       ped_req,
   output logic       walk,
`endif
   output logic [2:0] main_light,
   output logic [2:0] side_light
);

   state_t        state_r;
   state_t        state_nxt_s;
   logic          expired_s;
   logic          load_s;
   logic [TW-1:0] load_val_s;
   logic          side_pend_r;
   logic          side_pending_s;
   logic          req_any_s;
   lamps_t        lamps_s;

   // Dwell loaded on entry to a state is T-1 so the state lasts T cycles.
   function automatic logic [TW-1:0] dwell_of(input state_t st);
      logic [TW-1:0] d;
      case (st)
         MAIN_GREEN:     d = TW'(T_MIN_GREEN - 1);
         MAIN_AMBER:     d = TW'(T_AMBER - 1);
         ALL_RED_1:      d = TW'(T_ALL_RED - 1);
         SIDE_RED_AMBER: d = TW'(T_RED_AMBER - 1);
         SIDE_GREEN:     d = TW'(T_SIDE_GREEN - 1);
         SIDE_AMBER:     d = TW'(T_AMBER - 1);
         ALL_RED_2:      d = TW'(T_ALL_RED - 1);
         MAIN_RED_AMBER: d = TW'(T_RED_AMBER - 1);
`ifdef PED_CROSSING_EN
         WALK:           d = TW'(T_WALK - 1);
`endif
         default:        d = TW'(T_ALL_RED - 1);
      endcase
      return d;
   endfunction

   assign load_s     = (state_nxt_s != state_r);
   assign load_val_s = dwell_of(state_nxt_s);

   dwell_timer #(
      .TW      (TW),
      .RST_VAL (TW'(T_ALL_RED - 1))
   ) u_dwell_timer (
      .clk      (clk),
      .rst      (rst),
      .load     (load_s),
      .load_val (load_val_s),
      .expired  (expired_s)
   );

   // Side request latch: cleared on entry to side green, re-latched after.
   always_ff @(posedge clk) begin
      if (rst) begin
         side_pend_r <= 1'b0;
      end else if ((state_nxt_s == SIDE_GREEN) && (state_r != SIDE_GREEN)) begin
         side_pend_r <= 1'b0;
      end else if (side_req) begin
         side_pend_r <= 1'b1;
      end else begin
         side_pend_r <= side_pend_r;
      end
   end

   assign side_pending_s = side_pend_r | side_req;

`ifdef PED_CROSSING_EN
   logic ped_pend_r;
   logic ped_pending_s;

   // Pedestrian request latch: cleared on entry to WALK, re-latched after.
   always_ff @(posedge clk) begin
      if (rst) begin
         ped_pend_r <= 1'b0;
      end else if ((state_nxt_s == WALK) && (state_r != WALK)) begin
         ped_pend_r <= 1'b0;
      end else if (ped_req) begin
         ped_pend_r <= 1'b1;
      end else begin
         ped_pend_r <= ped_pend_r;
      end
   end

   assign ped_pending_s = ped_pend_r | ped_req;
   assign req_any_s     = side_pending_s | ped_pending_s;
`else
   assign req_any_s     = side_pending_s;
`endif

   // State register; reset lands in the final all-red clearance.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r <= ALL_RED_2;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic; timed states advance only when the dwell has expired.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         MAIN_GREEN: begin
            if (expired_s && req_any_s) state_nxt_s = MAIN_AMBER;
            else                        state_nxt_s = MAIN_GREEN;
         end
         MAIN_AMBER: begin
            if (expired_s) state_nxt_s = ALL_RED_1;
            else           state_nxt_s = MAIN_AMBER;
         end
         ALL_RED_1: begin
            if (!expired_s)          state_nxt_s = ALL_RED_1;
`ifdef PED_CROSSING_EN
            else if (!side_pending_s) state_nxt_s = WALK;
`endif
            else                     state_nxt_s = SIDE_RED_AMBER;
         end
         SIDE_RED_AMBER: begin
            if (expired_s) state_nxt_s = SIDE_GREEN;
            else           state_nxt_s = SIDE_RED_AMBER;
         end
         SIDE_GREEN: begin
            if (expired_s) state_nxt_s = SIDE_AMBER;
            else           state_nxt_s = SIDE_GREEN;
         end
         SIDE_AMBER: begin
            if (expired_s) state_nxt_s = ALL_RED_2;
            else           state_nxt_s = SIDE_AMBER;
         end
         ALL_RED_2: begin
            if (!expired_s)          state_nxt_s = ALL_RED_2;
`ifdef PED_CROSSING_EN
            else if (ped_pending_s)  state_nxt_s = WALK;
`endif
            else                     state_nxt_s = MAIN_RED_AMBER;
         end
`ifdef PED_CROSSING_EN
         WALK: begin
            if (expired_s) state_nxt_s = MAIN_RED_AMBER;
            else           state_nxt_s = WALK;
         end
`endif
         MAIN_RED_AMBER: begin
            if (expired_s) state_nxt_s = MAIN_GREEN;
            else           state_nxt_s = MAIN_RED_AMBER;
         end
         // Corrupted encoding recovers through the all-red clearance.
         default: state_nxt_s = ALL_RED_2;
      endcase
   end

   // Lamps depend on the state register only.
   assign lamps_s    = decode_lamps(state_r);
   assign main_light = lamps_s.main_l;
   assign side_light = lamps_s.side_l;
`ifdef PED_CROSSING_EN
   assign walk       = lamps_s.walk_l;
`else
   // No walk lamp in this build; the decoded bit is intentionally dropped.
   logic walk_unused_s;
   assign walk_unused_s = lamps_s.walk_l;
`endif

endmodule

// File: tb/tb_junction_controller.sv
// tb_junction_controller: directed self-checking bench for junction_controller.
// Pedestrian scenarios compile in only when PED_CROSSING_EN is defined.
module tb_junction_controller;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       side_req = 1'b0;
   logic [2:0] main_light;
   logic [2:0] side_light;
`ifdef PED_CROSSING_EN
   logic       ped_req = 1'b0;
   logic       walk;
`endif

   int checks = 0;
   int errors = 0;

   junction_controller dut (
      .clk        (clk),
      .rst        (rst),
      .side_req   (side_req),
`ifdef PED_CROSSING_EN
      .ped_req    (ped_req),
      .walk       (walk),
`endif
      .main_light (main_light),
      .side_light (side_light)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reset for two edges, release, and stop on the first MAIN_GREEN cycle.
   task automatic do_reset();
      rst = 1'b1;
      side_req = 1'b0;
`ifdef PED_CROSSING_EN
      ped_req = 1'b0;
`endif
      step();
      step();
      rst = 1'b0;
      repeat (4) step();
   endtask

   // Phase ids: 0 MG, 1 MA, 2 all-red, 3 SRA, 4 SG, 5 SA, 6 MRA, 7 WALK.
   // Returned as {main[2:0], side[2:0], walk}.
   function automatic logic [6:0] phase_lamps(int p);
      case (p)
         0: return 7'b001_100_0;
         1: return 7'b010_100_0;
         2: return 7'b100_100_0;
         3: return 7'b100_110_0;
         4: return 7'b100_001_0;
         5: return 7'b100_010_0;
         6: return 7'b110_100_0;
         7: return 7'b100_100_1;
         default: return 7'b000_000_0;
      endcase
   endfunction

   function automatic int phase_dur(int p);
      case (p)
         0: return 16;
         1: return 4;
         2: return 2;
         3: return 2;
         4: return 12;
         5: return 4;
         6: return 2;
         7: return 10;
         default: return 0;
      endcase
   endfunction

   // Scenario 0: side cycle. 1: pedestrian only. 2: side then walk.
   function automatic int seq_at(int scen, int i);
      case (scen)
         0: case (i) 0: return 0; 1: return 1; 2: return 2; 3: return 3;
                     4: return 4; 5: return 5; 6: return 2; 7: return 6;
                     default: return -1; endcase
         1: case (i) 0: return 0; 1: return 1; 2: return 2; 3: return 7;
                     4: return 6; default: return -1; endcase
         2: case (i) 0: return 0; 1: return 1; 2: return 2; 3: return 3;
                     4: return 4; 5: return 5; 6: return 2; 7: return 7;
                     8: return 6; default: return -1; endcase
         default: return -1;
      endcase
   endfunction

   // Expected lamps c cycles after MAIN_GREEN entry; rep repeats the round.
   function automatic logic [6:0] exp_at(int scen, int c, bit rep);
      int t;
      int total;
      t = c;
      total = 0;
      for (int i = 0; i < 10; i++) begin
         if (seq_at(scen, i) >= 0) total += phase_dur(seq_at(scen, i));
      end
      if (t >= total) begin
         if (rep) t = t % total;
         else return 7'b001_100_0;
      end
      for (int i = 0; i < 10; i++) begin
         if (seq_at(scen, i) < 0) break;
         if (t < phase_dur(seq_at(scen, i))) return phase_lamps(seq_at(scen, i));
         t -= phase_dur(seq_at(scen, i));
      end
      return 7'b001_100_0;
   endfunction

   task automatic test_reset();
      logic [5:0] exp_l [4];
      exp_l[0] = 6'b100_100;
      exp_l[1] = 6'b110_100;
      exp_l[2] = 6'b110_100;
      exp_l[3] = 6'b001_100;
      rst = 1'b1;
      side_req = 1'b1;
      step();
      step();
      side_req = 1'b0;
      checks++;
      if ({main_light, side_light} !== 6'b100_100) begin
         errors++;
         $display("FAIL reset_lamps got %b_%b want 100_100", main_light, side_light);
      end
`ifdef PED_CROSSING_EN
      checks++;
      if (walk !== 1'b0) begin
         errors++;
         $display("FAIL reset_walk got %b want 0", walk);
      end
`endif
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         checks++;
         if ({main_light, side_light} !== exp_l[i]) begin
            errors++;
            $display("FAIL reset_seq[%0d] got %b_%b want %b", i, main_light, side_light, exp_l[i]);
         end
      end
      // Requests during reset were ignored: green must rest.
      for (int i = 0; i < 100; i++) begin
         step();
         checks++;
         if ({main_light, side_light} !== 6'b001_100) begin
            errors++;
            $display("FAIL idle_green[%0d] got %b_%b want 001_100", i, main_light, side_light);
         end
      end
   endtask

   task automatic test_latency();
      do_reset();
      repeat (20) step();
      side_req = 1'b1;
      step();
      side_req = 1'b0;
      checks++;
      if (main_light !== 3'b010) begin
         errors++;
         $display("FAIL req_latency got %b want 010", main_light);
      end
   endtask

   task automatic test_side_pulse();
      logic [6:0] e;
      do_reset();
      for (int c = 0; c < 75; c++) begin
         e = exp_at(0, c, 1'b0);
         checks++;
         if ({main_light, side_light} !== e[6:1]) begin
            errors++;
            $display("FAIL side_pulse[%0d] got %b_%b want %b", c, main_light, side_light, e[6:1]);
         end
         side_req = (c == 5);
         step();
      end
      side_req = 1'b0;
   endtask

   task automatic test_side_held();
      logic [6:0] e;
      do_reset();
      side_req = 1'b1;
      for (int c = 0; c < 88; c++) begin
         e = exp_at(0, c, 1'b1);
         checks++;
         if ({main_light, side_light} !== e[6:1]) begin
            errors++;
            $display("FAIL side_held[%0d] got %b_%b want %b", c, main_light, side_light, e[6:1]);
         end
         step();
      end
      side_req = 1'b0;
   endtask

   task automatic test_reset_mid();
      logic [5:0] exp_l [4];
      exp_l[0] = 6'b100_100;
      exp_l[1] = 6'b110_100;
      exp_l[2] = 6'b110_100;
      exp_l[3] = 6'b001_100;
      do_reset();
      for (int c = 0; c < 28; c++) begin
         side_req = (c == 5) || (c == 26);
         step();
      end
      checks++;
      if ({main_light, side_light} !== 6'b100_001) begin
         errors++;
         $display("FAIL mid_in_side_green got %b_%b want 100_001", main_light, side_light);
      end
      rst = 1'b1;
      side_req = 1'b1;
      step();
      checks++;
      if ({main_light, side_light} !== 6'b100_100) begin
         errors++;
         $display("FAIL mid_rst_lamps got %b_%b want 100_100", main_light, side_light);
      end
      rst = 1'b0;
      side_req = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         checks++;
         if ({main_light, side_light} !== exp_l[i]) begin
            errors++;
            $display("FAIL mid_restart[%0d] got %b_%b want %b", i, main_light, side_light, exp_l[i]);
         end
      end
      // Pending side request must have been discarded by reset.
      for (int i = 0; i < 30; i++) begin
         step();
         checks++;
         if ({main_light, side_light} !== 6'b001_100) begin
            errors++;
            $display("FAIL mid_pend_cleared[%0d] got %b_%b want 001_100", i, main_light, side_light);
         end
      end
   endtask

`ifdef PED_CROSSING_EN
   task automatic test_ped(input int scen, input bit with_side);
      logic [6:0] e;
      do_reset();
      for (int c = 0; c < 70; c++) begin
         e = exp_at(scen, c, 1'b0);
         checks++;
         if ({main_light, side_light, walk} !== e) begin
            errors++;
            $display("FAIL ped_scen%0d[%0d] got %b_%b_%b want %b", scen, c,
                     main_light, side_light, walk, e);
         end
         ped_req  = (c == 2);
         side_req = (c == 2) && with_side;
         step();
      end
      ped_req  = 1'b0;
      side_req = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_latency();
      test_side_pulse();
      test_side_held();
      test_reset_mid();
`ifdef PED_CROSSING_EN
      test_ped(1, 1'b0);
      test_ped(2, 1'b1);
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
